ddr_cmd_scheduler: RTL and testbench
====================================

Name: ddr_cmd_scheduler

Overview:
- Arbitrates NREQ bank-access requesters and sequences DDR commands (PR, ACT, RD/WR, PRA, REF) onto the single command bus.
- The command bus feeds the per-bank TimingFSM array.
- Tracks the open row per bank and enforces tRP/tRCD/tRFC spacing.
- Schedules periodic refresh every TREFI cycles.

Parameters:
- BGWIDTH, 2, bank-group address width
- BAWIDTH, 2, bank address width
- ROWWIDTH, 16, row address width
- NREQ, 4, number of requesters (>=2)
- TRP, 4, PR/PRA to ACT/REF spacing, cycles (>=2)
- TRCD, 4, ACT to RD/WR spacing, cycles (>=2)
- TRFC, 16, REF to next command spacing, cycles (>=2)
- TREFI, 1024, refresh interval, cycles (>=TRP+TRFC+8)

Ports:
- clk  in  1  clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_we  in  NREQ  1=write, 0=read
- req_bg  in  NREQ*BGWIDTH  packed bank group; requester i at [i*BGWIDTH +: BGWIDTH]
- req_ba  in  NREQ*BAWIDTH  packed bank address
- req_row  in  NREQ*ROWWIDTH  packed row address
- req_ready  out  NREQ  one-hot pulse; request served (column command issued this cycle)
- ACT, PR, PRA, RD, WR, REF  out  1 each  command strobes, at most one high per cycle
- cmd_bg  out  BGWIDTH  target bank group of the current command
- cmd_ba  out  BAWIDTH  target bank of the current command
- cmd_row  out  ROWWIDTH  row for ACT; don't-care otherwise
- busy  out  1  high whenever state != IDLE
- ref_pending  out  1  refresh owed and not yet issued

Behaviour:
- All outputs are registered. On reset (reset_n=0 at a clk edge):
  - all strobes, req_ready, busy, ref_pending, cmd_* = 0
  - open_vld[all banks]=0; RR pointer=0; refresh counter=0; state=IDLE
- Reset mid-sequence aborts immediately. No command is completed.
- Requester protocol:
  - Hold valid and all fields stable until req_ready.
  - If valid drops after grant, the latched request is still served and req_ready still pulses.
- Refresh counter:
  - Increments every cycle; at TREFI-1 it wraps to 0 and sets ref_pending.
  - A second expiry while pending keeps it at 1 (no accumulation).
  - ref_pending clears in the cycle REF is issued.
- States: IDLE, PRE, WAIT_RP, ACTV, WAIT_RCD, COL, RPRA, RWAIT_RP, RREF, RWAIT_RFC.
- IDLE, cycle t:
  - if ref_pending -> RPRA (refresh has priority over new requests, never preempts an in-flight request)
  - else if any req_valid: round-robin pick starting at the pointer; latch winner id, bg, ba, row, we; pointer <= winner+1 mod NREQ
  - then look up the bank ({bg,ba}):
    - open_vld && row match -> COL
    - !open_vld -> ACTV
    - open_vld && row mismatch -> PRE
- PRE: PR strobe with the latched bg/ba; clear open_vld[bank]. ACT follows exactly TRP cycles after PR.
- ACTV: ACT strobe with cmd_row; set open_vld and open_row. RD/WR follows exactly TRCD cycles after ACT.
- COL: RD or WR strobe per we, plus req_ready[id]. Next state IDLE.
- Latency from the IDLE decision cycle t:
  - row hit: column command at t+1
  - bank closed: ACT at t+1, column at t+1+TRCD
  - row conflict: PR at t+1, ACT at t+1+TRP, column at t+1+TRP+TRCD
- Refresh sequence:
  - RPRA: PRA strobe (always issued, even if all banks are closed); clear all open_vld.
  - REF issued TRP cycles after PRA.
  - IDLE re-entered TRFC cycles after REF.
- Wait counters load the relevant parameter minus 2 and count down. Width is $clog2 of the largest parameter.
- No auto-precharge. Rows stay open after RD/WR (open-page policy).

Decomposition:
- ddr_sched_pkg:
  - state enum
  - bank-index function ({bg,ba} to index)
  - timing-parameter defaults
- Sub-module rr_arbiter (NREQ): request vector + pointer -> one-hot grant and binary index; combinational; the pointer lives in the scheduler.

Test Plan:
- Bank closed: req0 read bg=1 ba=2 row=0x0055 at IDLE cycle 10 -> ACT at 11 (row 0x0055), RD at 15, req_ready[0] at 15.
- Row hit: then same bank and row, write, seen at cycle 16 -> WR and req_ready at 17; no ACT or PR.
- Row conflict: same bank, row 0x0077, seen at cycle 18 -> PR 19, ACT 23, RD 27.
- Round-robin: all 4 req_valid held high, all targeting open rows -> grants in order 0,1,2,3,0, one every 2 cycles.
- Refresh: TREFI=64 override with a request pending at expiry -> the in-flight request completes; then PRA, REF TRP later, ref_pending clears with REF; the waiting request is served after TRFC; a following ACT is required since PRA closed all banks.
- Reset: assert reset_n=0 during WAIT_RCD -> next cycle all outputs are 0; after release the same request goes ACT again (bank seen as closed).

Source files
------------

// File: rtl/ddr_sched_pkg.sv
// Shared types, timing defaults and helpers for the DDR command scheduler.
package ddr_sched_pkg;

    // Default geometry and timing (cycles)
    localparam int DEF_BGWIDTH  = 2;
    localparam int DEF_BAWIDTH  = 2;
    localparam int DEF_ROWWIDTH = 16;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_TRP      = 4;
    localparam int DEF_TRCD     = 4;
    localparam int DEF_TRFC     = 16;
    localparam int DEF_TREFI    = 1024;

    // Scheduler states: request path, then refresh path
    typedef enum logic [3:0] {
        IDLE,
        PRE,
        WAIT_RP,
        ACTV,
        WAIT_RCD,
        COL,
        RPRA,
        RWAIT_RP,
        RREF,
        RWAIT_RFC
    } state_e;

    // Flat bank index: bank group in the upper bits, bank in the lower bits
    function automatic int unsigned bank_index(input int unsigned bg,
                                               input int unsigned ba,
                                               input int unsigned ba_width);
        return (bg << ba_width) | ba;
    endfunction

    // Largest of three timing values; sizes the shared wait counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_rr_arbiter.sv
// Round-robin arbiter: first active request at or after the pointer wins.
// Purely combinational; the pointer register lives in the scheduler.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan NREQ positions starting at the pointer, wrapping modulo NREQ
    always_comb begin
        // NOTE: every output gets a default before any conditional write, so no path holds an old value and no latch is inferred.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            int cand;
            cand = (int'(ptr_i) + off) % NREQ;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: round-robin arbitration of bank requests,
// open-page row tracking, tRP/tRCD/tRFC spacing and periodic refresh.
// Every output comes straight from a flop loaded with next-state values.
module ddr_cmd_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int BGWIDTH  = DEF_BGWIDTH,
    parameter int BAWIDTH  = DEF_BAWIDTH,
    parameter int ROWWIDTH = DEF_ROWWIDTH,
    parameter int NREQ     = DEF_NREQ,
    parameter int TRP      = DEF_TRP,
    parameter int TRCD     = DEF_TRCD,
    parameter int TRFC     = DEF_TRFC,
    parameter int TREFI    = DEF_TREFI
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*BGWIDTH-1:0]  req_bg,
    input  logic [NREQ*BAWIDTH-1:0]  req_ba,
    input  logic [NREQ*ROWWIDTH-1:0] req_row,
    output logic [NREQ-1:0]          req_ready,
    output logic                     ACT,
    output logic                     PR,
    output logic                     PRA,
    output logic                     RD,
    output logic                     WR,
    output logic                     REF,
    output logic [BGWIDTH-1:0]       cmd_bg,
    output logic [BAWIDTH-1:0]       cmd_ba,
    output logic [ROWWIDTH-1:0]      cmd_row,
    output logic                     busy,
    output logic                     ref_pending
);

    localparam int NBANK_W = BGWIDTH + BAWIDTH;
    localparam int NBANK   = 1 << NBANK_W;
    localparam int IDX_W   = $clog2(NREQ);
    localparam int CNT_W   = $clog2(max3(TRP, TRCD, TRFC));
    localparam int REF_W   = $clog2(TREFI);

    // Wait counters load (parameter - 2): one cycle is spent in the command
    // state itself and the wait state exits on the zero count.
    localparam logic [CNT_W-1:0] LOAD_RP   = CNT_W'(TRP - 2);
    localparam logic [CNT_W-1:0] LOAD_RCD  = CNT_W'(TRCD - 2);
    localparam logic [CNT_W-1:0] LOAD_RFC  = CNT_W'(TRFC - 2);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(TREFI - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREQ - 1);

    // ---------------- state ----------------
    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [REF_W-1:0]     ref_cnt_q, ref_cnt_d;
    logic                 ref_pending_q, ref_pending_d;

    // Latched winning request
    logic [NREQ-1:0]      lat_gnt_q, lat_gnt_d;
    logic [BGWIDTH-1:0]   lat_bg_q, lat_bg_d;
    logic [BAWIDTH-1:0]   lat_ba_q, lat_ba_d;
    logic [ROWWIDTH-1:0]  lat_row_q, lat_row_d;
    logic                 lat_we_q, lat_we_d;

    // Per-bank open-row tracking
    logic [NBANK-1:0]     open_vld_q, open_vld_d;
    logic [ROWWIDTH-1:0]  open_row_q [NBANK];

    // Registered outputs
    logic                 act_q, pr_q, pra_q, rd_q, wr_q, ref_q, busy_q;
    logic [NREQ-1:0]      ready_q;
    logic [BGWIDTH-1:0]   cmd_bg_q;
    logic [BAWIDTH-1:0]   cmd_ba_q;
    logic [ROWWIDTH-1:0]  cmd_row_q;

    // ---------------- arbitration ----------------
    logic [NREQ-1:0]      arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Winner's fields and its bank's open-row status
    logic [BGWIDTH-1:0]   win_bg;
    logic [BAWIDTH-1:0]   win_ba;
    logic [ROWWIDTH-1:0]  win_row;
    logic                 win_we;
    logic [NBANK_W-1:0]   win_bank;
    logic [NBANK_W-1:0]   lat_bank;
    logic                 win_open;
    logic                 win_row_hit;

    assign win_bg      = req_bg[arb_idx*BGWIDTH +: BGWIDTH];
    assign win_ba      = req_ba[arb_idx*BAWIDTH +: BAWIDTH];
    assign win_row     = req_row[arb_idx*ROWWIDTH +: ROWWIDTH];
    assign win_we      = req_we[arb_idx];
    assign win_bank    = NBANK_W'(bank_index(32'(win_bg), 32'(win_ba), BAWIDTH));
    assign lat_bank    = NBANK_W'(bank_index(32'(lat_bg_q), 32'(lat_ba_q), BAWIDTH));
    assign win_open    = open_vld_q[win_bank];
    assign win_row_hit = (open_row_q[win_bank] == win_row);

    // Next-state logic: command sequencing, request latch and RR pointer
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wait_d    = wait_q;
        lat_gnt_d = lat_gnt_q;
        lat_bg_d  = lat_bg_q;
        lat_ba_d  = lat_ba_q;
        lat_row_d = lat_row_q;
        lat_we_d  = lat_we_q;

        case (state_q)
            IDLE: begin
                // Refresh wins here but never interrupts a request in flight
                if (ref_pending_q) begin
                    state_d = RPRA;
                end else if (arb_any) begin
                    lat_gnt_d = arb_grant;
                    lat_bg_d  = win_bg;
                    lat_ba_d  = win_ba;
                    lat_row_d = win_row;
                    lat_we_d  = win_we;
                    ptr_d     = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
                    if (win_open && win_row_hit) state_d = COL;
                    else if (win_open)           state_d = PRE;
                    else                         state_d = ACTV;
                end
            end
            PRE: begin
                wait_d  = LOAD_RP;
                state_d = WAIT_RP;
            end
            WAIT_RP: begin
                if (wait_q == '0) state_d = ACTV;
                else              wait_d  = wait_q - 1'b1;
            end
            ACTV: begin
                wait_d  = LOAD_RCD;
                state_d = WAIT_RCD;
            end
            WAIT_RCD: begin
                if (wait_q == '0) state_d = COL;
                else              wait_d  = wait_q - 1'b1;
            end
            COL: begin
                state_d = IDLE;
            end
            RPRA: begin
                wait_d  = LOAD_RP;
                state_d = RWAIT_RP;
            end
            RWAIT_RP: begin
                if (wait_q == '0) state_d = RREF;
                else              wait_d  = wait_q - 1'b1;
            end
            RREF: begin
                wait_d  = LOAD_RFC;
                state_d = RWAIT_RFC;
            end
            RWAIT_RFC: begin
                if (wait_q == '0) state_d = IDLE;
                else              wait_d  = wait_q - 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Refresh interval counter and the owed-refresh flag
    always_comb begin
        ref_cnt_d     = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + 1'b1;
        ref_pending_d = ref_pending_q;
        if (state_d == RREF)       ref_pending_d = 1'b0;
        // A fresh expiry outranks the clear so a refresh is never lost
        if (ref_cnt_q == REF_LAST) ref_pending_d = 1'b1;
    end

    // Open-bank bookkeeping, updated in the cycle each command is on the bus
    always_comb begin
        open_vld_d = open_vld_q;
        case (state_q)
            PRE:     open_vld_d[lat_bank] = 1'b0;
            ACTV:    open_vld_d[lat_bank] = 1'b1;
            RPRA:    open_vld_d           = '0;
            default: ;
        endcase
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            wait_q        <= '0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            lat_gnt_q     <= '0;
            lat_bg_q      <= '0;
            lat_ba_q      <= '0;
            lat_row_q     <= '0;
            lat_we_q      <= 1'b0;
            open_vld_q    <= '0;
            act_q         <= 1'b0;
            pr_q          <= 1'b0;
            pra_q         <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            ref_q         <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= '0;
            cmd_bg_q      <= '0;
            cmd_ba_q      <= '0;
            cmd_row_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wait_q        <= wait_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            lat_gnt_q     <= lat_gnt_d;
            lat_bg_q      <= lat_bg_d;
            lat_ba_q      <= lat_ba_d;
            lat_row_q     <= lat_row_d;
            lat_we_q      <= lat_we_d;
            open_vld_q    <= open_vld_d;
            act_q         <= (state_d == ACTV);
            pr_q          <= (state_d == PRE);
            pra_q         <= (state_d == RPRA);
            rd_q          <= (state_d == COL) && !lat_we_d;
            wr_q          <= (state_d == COL) &&  lat_we_d;
            ref_q         <= (state_d == RREF);
            busy_q        <= (state_d != IDLE);
            ready_q       <= (state_d == COL) ? lat_gnt_d : '0;
            cmd_bg_q      <= lat_bg_d;
            cmd_ba_q      <= lat_ba_d;
            cmd_row_q     <= lat_row_d;
        end
    end

    // Open-row storage, written on ACT
    // NOTE: this array is deliberately not reset; open_vld guards every read, so stale rows are never acted on.
    always_ff @(posedge clk) begin
        if (state_q == ACTV) open_row_q[lat_bank] <= lat_row_q;
    end

    assign ACT         = act_q;
    assign PR          = pr_q;
    assign PRA         = pra_q;
    assign RD          = rd_q;
    assign WR          = wr_q;
    assign REF         = ref_q;
    assign busy        = busy_q;
    assign req_ready   = ready_q;
    assign cmd_bg      = cmd_bg_q;
    assign cmd_ba      = cmd_ba_q;
    assign cmd_row     = cmd_row_q;
    assign ref_pending = ref_pending_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: a per-cycle vector table for the
// closed/hit/conflict sequence, plus hand-written round-robin, mid-sequence
// reset and refresh sequences. Cycle 0 is the first cycle after reset.
module tb_ddr_cmd_scheduler;

    localparam int NREQ = 4;
    localparam int BGW  = 2;
    localparam int BAW  = 2;
    localparam int RW   = 16;

    // Strobe encodings in {ACT, PR, PRA, RD, WR, REF} order
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_ACT  = 6'b100000;
    localparam logic [5:0] C_PR   = 6'b010000;
    localparam logic [5:0] C_PRA  = 6'b001000;
    localparam logic [5:0] C_RD   = 6'b000100;
    localparam logic [5:0] C_WR   = 6'b000010;
    localparam logic [5:0] C_REF  = 6'b000001;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ*BGW-1:0]  req_bg = '0;
    logic [NREQ*BAW-1:0]  req_ba = '0;
    logic [NREQ*RW-1:0]   req_row = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 ACT, PR, PRA, RD, WR, REF;
    logic [BGW-1:0]       cmd_bg;
    logic [BAW-1:0]       cmd_ba;
    logic [RW-1:0]        cmd_row;
    logic                 busy;
    logic                 ref_pending;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    ddr_cmd_scheduler #(
        .BGWIDTH (BGW), .BAWIDTH (BAW), .ROWWIDTH (RW), .NREQ (NREQ),
        .TRP (4), .TRCD (4), .TRFC (16), .TREFI (64)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .req_valid (req_valid), .req_we (req_we), .req_bg (req_bg),
        .req_ba (req_ba), .req_row (req_row), .req_ready (req_ready),
        .ACT (ACT), .PR (PR), .PRA (PRA), .RD (RD), .WR (WR), .REF (REF),
        .cmd_bg (cmd_bg), .cmd_ba (cmd_ba), .cmd_row (cmd_row),
        .busy (busy), .ref_pending (ref_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          cyc;
        logic        vld;
        logic        we;
        logic [15:0] row;
        logic [5:0]  cmd;
        logic [15:0] crow;
        logic        rdy;
        logic        busy;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic [5:0] e_cmd, input logic [3:0] e_rdy,
                               input logic e_busy, input logic e_refp,
                               input logic chk_addr, input logic [1:0] e_bg, input logic [1:0] e_ba,
                               input logic chk_row, input logic [15:0] e_row);
        check({tag, ".cmd"},   64'({ACT, PR, PRA, RD, WR, REF}), 64'(e_cmd));
        check({tag, ".ready"}, 64'(req_ready), 64'(e_rdy));
        check({tag, ".busy"},  64'(busy), 64'(e_busy));
        check({tag, ".refp"},  64'(ref_pending), 64'(e_refp));
        if (chk_addr) begin
            check({tag, ".bg"}, 64'(cmd_bg), 64'(e_bg));
            check({tag, ".ba"}, 64'(cmd_ba), 64'(e_ba));
        end
        if (chk_row) check({tag, ".row"}, 64'(cmd_row), 64'(e_row));
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [1:0] bg, input logic [1:0] ba, input logic [15:0] row);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_bg[i*BGW +: BGW]  = bg;
        req_ba[i*BAW +: BAW]  = ba;
        req_row[i*RW +: RW]   = row;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [5:0]  e_cmd;
        logic [3:0]  e_rdy;
        logic        e_busy, e_refp, chk_addr, chk_row;
        logic [1:0]  e_bg, e_ba;
        logic [15:0] e_row;
        int          id;

        // Closed -> hit -> conflict on bank (bg=1, ba=2), requester 0
        vecs[0]  = '{10, 1'b1, 1'b0, 16'h0055, C_NONE, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{11, 1'b1, 1'b0, 16'h0055, C_ACT,  16'h0055, 1'b0, 1'b1};
        vecs[2]  = '{12, 1'b1, 1'b0, 16'h0055, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[3]  = '{13, 1'b1, 1'b0, 16'h0055, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[4]  = '{14, 1'b1, 1'b0, 16'h0055, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[5]  = '{15, 1'b1, 1'b0, 16'h0055, C_RD,   16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16, 1'b1, 1'b1, 16'h0055, C_NONE, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{17, 1'b1, 1'b1, 16'h0055, C_WR,   16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{18, 1'b1, 1'b0, 16'h0077, C_NONE, 16'h0000, 1'b0, 1'b0};
        // valid dropped after grant: the latched request must still complete
        vecs[9]  = '{19, 1'b0, 1'b0, 16'h0077, C_PR,   16'h0000, 1'b0, 1'b1};
        vecs[10] = '{20, 1'b0, 1'b0, 16'h0077, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{21, 1'b0, 1'b0, 16'h0077, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[12] = '{22, 1'b0, 1'b0, 16'h0077, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[13] = '{23, 1'b0, 1'b0, 16'h0077, C_ACT,  16'h0077, 1'b0, 1'b1};
        vecs[14] = '{24, 1'b0, 1'b0, 16'h0077, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[15] = '{25, 1'b0, 1'b0, 16'h0077, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[16] = '{26, 1'b0, 1'b0, 16'h0077, C_NONE, 16'h0000, 1'b0, 1'b1};
        vecs[17] = '{27, 1'b0, 1'b0, 16'h0077, C_RD,   16'h0000, 1'b1, 1'b1};

        // Power-on reset
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
        @(negedge clk);
        check_cycle("reset", C_NONE, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 16'h0000);

        // Table-driven sequence
        for (int i = 0; i < 18; i++) begin
            while (cyc < vecs[i].cyc) next_cycle();
            set_req(0, vecs[i].vld, vecs[i].we, 2'd1, 2'd2, vecs[i].row);
            @(negedge clk);
            check_cycle($sformatf("vec%0d", i), vecs[i].cmd, {3'b000, vecs[i].rdy}, vecs[i].busy,
                        1'b0, (vecs[i].cmd != C_NONE), 2'd1, 2'd2,
                        (vecs[i].cmd == C_ACT), vecs[i].crow);
            next_cycle();
        end

        // Round-robin: requester 3 alone first (row hit) to bring the pointer to 0
        set_req(3, 1'b1, 1'b1, 2'd1, 2'd2, 16'h0077);
        @(negedge clk);
        check_cycle("rr_pre_dec", C_NONE, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0);
        next_cycle();
        @(negedge clk);
        check_cycle("rr_pre_col", C_WR, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 16'h0);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 2'd1, 2'd2, 16'h0077);
        set_req(1, 1'b1, 1'b1, 2'd1, 2'd2, 16'h0077);
        set_req(2, 1'b1, 1'b0, 2'd1, 2'd2, 16'h0077);
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            @(negedge clk);
            check_cycle($sformatf("rr%0d_dec", k), C_NONE, 4'b0000, 1'b0, 1'b0,
                        1'b0, 2'd0, 2'd0, 1'b0, 16'h0);
            next_cycle();
            @(negedge clk);
            check_cycle($sformatf("rr%0d_col", k), (id % 2 == 1) ? C_WR : C_RD,
                        4'(1 << id), 1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 16'h0);
            next_cycle();
        end
        req_valid = '0;

        // Mid-sequence reset: requester 2 to closed bank (bg=0, ba=1)
        @(negedge clk);
        check_cycle("rst_idle", C_NONE, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0);
        next_cycle();
        set_req(2, 1'b1, 1'b0, 2'd0, 2'd1, 16'h0123);
        @(negedge clk);
        check_cycle("rst_dec", C_NONE, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0);
        next_cycle();
        @(negedge clk);
        check_cycle("rst_act", C_ACT, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 16'h0123);
        next_cycle();
        reset_n = 1'b0;
        @(negedge clk);
        check_cycle("rst_wait", C_NONE, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0);
        next_cycle();
        reset_n = 1'b1;
        cyc     = 0;

        // After release: all outputs zero, then the same request goes ACT again
        for (int c = 0; c <= 6; c++) begin
            if (c == 6) req_valid[2] = 1'b0;
            e_cmd = C_NONE; e_rdy = '0; chk_addr = 1'b0; chk_row = 1'b0;
            e_bg = 2'd0; e_ba = 2'd1; e_row = 16'h0123;
            case (c)
                0: begin chk_addr = 1'b1; chk_row = 1'b1; e_ba = 2'd0; e_row = 16'h0; end
                1: begin e_cmd = C_ACT; chk_addr = 1'b1; chk_row = 1'b1; end
                5: begin e_cmd = C_RD; e_rdy = 4'b0100; chk_addr = 1'b1; end
                default: ;
            endcase
            e_busy = (c >= 1 && c <= 5);
            @(negedge clk);
            check_cycle($sformatf("post_rst_c%0d", c), e_cmd, e_rdy, e_busy, 1'b0,
                        chk_addr, e_bg, e_ba, chk_row, e_row);
            next_cycle();
        end

        // Refresh: expiry at cycle 63 lands while requester 0 is in WAIT_RCD
        while (cyc < 60) next_cycle();
        for (int c = 60; c <= 93; c++) begin
            if (c == 60) set_req(0, 1'b1, 1'b0, 2'd2, 2'd3, 16'h0AAA);
            if (c == 61) set_req(1, 1'b1, 1'b1, 2'd1, 2'd2, 16'h0077);
            if (c == 66) req_valid[0] = 1'b0;
            if (c == 93) req_valid[1] = 1'b0;
            e_cmd = C_NONE; e_rdy = '0; chk_addr = 1'b0; chk_row = 1'b0;
            e_bg = 2'd0; e_ba = 2'd0; e_row = 16'h0;
            case (c)
                61: begin e_cmd = C_ACT; chk_addr = 1'b1; chk_row = 1'b1;
                          e_bg = 2'd2; e_ba = 2'd3; e_row = 16'h0AAA; end
                65: begin e_cmd = C_RD; e_rdy = 4'b0001; chk_addr = 1'b1;
                          e_bg = 2'd2; e_ba = 2'd3; end
                67: e_cmd = C_PRA;
                71: e_cmd = C_REF;
                88: begin e_cmd = C_ACT; chk_addr = 1'b1; chk_row = 1'b1;
                          e_bg = 2'd1; e_ba = 2'd2; e_row = 16'h0077; end
                92: begin e_cmd = C_WR; e_rdy = 4'b0010; chk_addr = 1'b1;
                          e_bg = 2'd1; e_ba = 2'd2; end
                default: ;
            endcase
            e_busy = (c >= 61 && c <= 65) || (c >= 67 && c <= 86) || (c >= 88 && c <= 92);
            e_refp = (c >= 64 && c <= 70);
            @(negedge clk);
            check_cycle($sformatf("refresh_c%0d", c), e_cmd, e_rdy, e_busy, e_refp,
                        chk_addr, e_bg, e_ba, chk_row, e_row);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
